// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and the latency-counter width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110,
        MDU_RSVD  = 3'b111
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Bits needed to hold the longer of the two latencies.
    function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable down-counter that times the Busy window of a multiply/divide.
// done is high in the cycle whose closing edge takes the count from 1 to 0.
module mdu_latency_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done,
    output logic          nonzero
);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign nonzero = (count != '0);
    assign done    = (count == CW'(1)) && !load;

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at issue, held as pending, and committed when the latency expires.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e state, next_state;
    mdu_op_e    op;

    logic          cnt_load, cnt_done, cnt_nonzero;
    logic [CW-1:0] cnt_val;
    logic          mt_hi, mt_lo, commit;

    logic [WIDTH-1:0] pend_hi, pend_lo, pend_hi_d, pend_lo_d;
    logic             pend_wr, pend_wr_d;

    assign op = mdu_op_e'(MDUOP);

    // Arithmetic datapath, evaluated on the issue cycle operands.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               div_by_zero, div_ovf;
    logic [WIDTH-1:0]   divisor_s, divisor_u, quot_u, rem_u;
    logic signed [WIDTH-1:0] quot_s, rem_s;

    assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Dividing by 1 yields the required results for the signed overflow case
    // and keeps the divider well-defined when B is zero (result discarded).
    assign div_by_zero = (B == '0);
    assign div_ovf     = (A == MOST_NEG) && (B == '1);
    assign divisor_s   = (div_by_zero || div_ovf) ? WIDTH'(1) : B;
    assign divisor_u   = div_by_zero ? WIDTH'(1) : B;

    assign quot_s = $signed(A) / $signed(divisor_s);
    assign rem_s  = $signed(A) % $signed(divisor_s);
    assign quot_u = A / divisor_u;
    assign rem_u  = A % divisor_u;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        pend_hi_d = '0;
        pend_lo_d = '0;
        pend_wr_d = 1'b1;
        case (op)
            MDU_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
            MDU_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
            MDU_DIV: begin
                pend_hi_d = rem_s;
                pend_lo_d = quot_s;
                pend_wr_d = !div_by_zero;
            end
            MDU_DIVU: begin
                pend_hi_d = rem_u;
                pend_lo_d = quot_u;
                pend_wr_d = !div_by_zero;
            end
            default: pend_wr_d = 1'b0;
        endcase
    end

    mdu_latency_counter #(.CW(CW)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done),
        .nonzero  (cnt_nonzero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MDU_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (Start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            cnt_load   = 1'b1;
                            cnt_val    = CW'(MULT_CYCLES);
                            next_state = MDU_BUSY;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            cnt_load   = 1'b1;
                            cnt_val    = CW'(DIV_CYCLES);
                            next_state = MDU_BUSY;
                        end
                        MDU_MTHI: mt_hi = 1'b1;
                        MDU_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MDU_BUSY: begin
                // An empty counter here can only mean a lost count; fall back to IDLE.
                if (cnt_done || !cnt_nonzero) begin
                    next_state = MDU_IDLE;
                end
            end
            default: next_state = MDU_IDLE;
        endcase
    end

    assign commit = (state == MDU_BUSY) && cnt_done;
    assign Busy   = (state == MDU_BUSY);

    // NOTE: the pending registers are reset as well, so an operation aborted by
    // reset leaves nothing behind that a later commit could expose.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (cnt_load) begin
            pend_hi <= pend_hi_d;
            pend_lo <= pend_lo_d;
            pend_wr <= pend_wr_d;
        end
    end

    // Commit happens only in BUSY and MTHI/MTLO only in IDLE, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else begin
            if (commit && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (mt_hi) HI <= A;
            if (mt_lo) LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized ops checked against an arithmetic model.
module tb_mdu_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         Start = 1'b0;
    logic [2:0]   MDUOP = 3'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOP (MDUOP),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU: return MC;
            OP_DIV, OP_DIVU:   return DC;
            default:           return 0;
        endcase
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural operation.
    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] hi_in, input logic [W-1:0] lo_in,
                                      output logic [W-1:0] hi_o, output logic [W-1:0] lo_o);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        hi_o = hi_in;
        lo_o = lo_in;
        case (op)
            OP_MULT: begin
                p = sa * sb;
                hi_o = p[63:32];
                lo_o = p[31:0];
            end
            OP_MULTU: begin
                p = ua * ub;
                hi_o = p[63:32];
                lo_o = p[31:0];
            end
            OP_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                hi_o = r[31:0];
                lo_o = q[31:0];
            end
            OP_DIVU: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                hi_o = ur[31:0];
                lo_o = uq[31:0];
            end
            OP_MTHI: hi_o = a;
            OP_MTLO: lo_o = a;
            default: ;
        endcase
    endfunction

    // Called at a negedge: drives the op for one cycle, checks the Busy window
    // with HI/LO held, then the committed values. Returns at the negedge of
    // the cycle in which Busy has fallen.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        n = lat(op);
        Start = 1'b1;
        MDUOP = op;
        A = a;
        B = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOP = 3'($urandom);
        A = $urandom;
        B = $urandom;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s busy c%0d", tag, i + 1), W'(Busy), W'(1));
            check($sformatf("%s hi held c%0d", tag, i + 1), HI, m_hi);
            check($sformatf("%s lo held c%0d", tag, i + 1), LO, m_lo);
            @(negedge clk);
        end
        check($sformatf("%s busy end", tag), W'(Busy), W'(0));
        check($sformatf("%s hi", tag), HI, exp_hi);
        check($sformatf("%s lo", tag), LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra, rb, eh, el;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{OP_MTHI,  32'h00000011, 32'd0,        32'h00000011, 32'h80000000};
        vecs[5]  = '{OP_MTLO,  32'h00000022, 32'd0,        32'h00000011, 32'h00000022};
        vecs[6]  = '{OP_DIVU,  32'd9,        32'd0,        32'h00000011, 32'h00000022};
        vecs[7]  = '{OP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h00000022};
        vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[9]  = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[10] = '{OP_NOP,   32'h5,        32'h6,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[11] = '{OP_RSVD,  32'h7,        32'h8,        32'hFFFFFFFF, 32'hFFFFFFEB};

        // Reset with a MULT request present; it must not start.
        reset = 1'b1;
        Start = 1'b1;
        MDUOP = OP_MULT;
        A = 32'h3;
        B = 32'h4;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        Start = 1'b0;
        check("reset busy", W'(Busy), W'(0));
        check("reset hi", HI, '0);
        check("reset lo", LO, '0);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Back-to-back: second MULTU issued in the cycle Busy falls.
        @(negedge clk);
        run_op("b2b_first", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);
        run_op("b2b_second", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        // MTLO and a second MULT during Busy must both be ignored.
        @(negedge clk);
        Start = 1'b1;
        MDUOP = OP_MULT;
        A = 32'd3;
        B = 32'd4;
        @(negedge clk);
        for (int i = 0; i < MC; i++) begin
            check($sformatf("ign busy c%0d", i + 1), W'(Busy), W'(1));
            check($sformatf("ign hi held c%0d", i + 1), HI, m_hi);
            check($sformatf("ign lo held c%0d", i + 1), LO, m_lo);
            Start = (i < 2);
            MDUOP = (i == 0) ? OP_MTLO : OP_MULT;
            A = (i == 0) ? 32'h0000DEAD : 32'd9;
            B = 32'd9;
            @(negedge clk);
        end
        Start = 1'b0;
        check("ign busy end", W'(Busy), W'(0));
        check("ign hi", HI, 32'h0);
        check("ign lo", LO, 32'd12);
        m_hi = 32'h0;
        m_lo = 32'd12;
        @(negedge clk);
        check("ign no restart busy", W'(Busy), W'(0));
        check("ign no restart lo", LO, 32'd12);

        // Reset in cycle 3 of a DIV aborts it; nothing commits afterwards.
        Start = 1'b1;
        MDUOP = OP_DIV;
        A = 32'd100;
        B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        check("rst_div busy c1", W'(Busy), W'(1));
        @(negedge clk);
        check("rst_div busy c2", W'(Busy), W'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_div busy", W'(Busy), W'(0));
        check("rst_div hi", HI, '0);
        check("rst_div lo", LO, '0);
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            check($sformatf("rst_div no commit busy c%0d", i), W'(Busy), W'(0));
            check($sformatf("rst_div no commit lo c%0d", i), LO, '0);
        end

        // Randomized ops against the arithmetic model.
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = '1;
                2: begin
                    rop = OP_DIV;
                    ra = 32'h80000000;
                    rb = '1;
                end
                3: begin
                    ra = 32'($urandom_range(0, 40)) - 32'd20;
                    rb = 32'($urandom_range(0, 10)) - 32'd5;
                end
                default: ;
            endcase
            ref_model(rop, ra, rb, m_hi, m_lo, eh, el);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, eh, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
